// File: rtl/dk_game_pkg.sv
// rtl/dk_game_pkg.sv - shared types and constants for the round controller
// Purpose : round state encoding, winner codes, default timing constants and
//           a saturating score-increment helper.
// Ports   : none (package).
package dk_game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INTRO      = 3'd1,
    FIGHT      = 3'd2,
    KO         = 3'd3,
    MATCH_OVER = 3'd4
  } round_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam int DEF_ROUND_TIME     = 9;
  localparam int DEF_FRAMES_PER_SEC = 60;
  localparam int DEF_INTRO_FRAMES   = 120;
  localparam int DEF_KO_FRAMES      = 90;
  localparam int DEF_WINS_TO_MATCH  = 5;

  // Scores stop at the match threshold and never wrap.
  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
    return (v < lim) ? v + 3'd1 : v;
  endfunction

endpackage

// File: rtl/dk_round_timer.sv
// rtl/dk_round_timer.sv - frame-driven seconds down-counter feeding gameTime
// Purpose : sec_cnt counts frame ticks; every FRAMES_PER_SEC ticks gameTime
//           decrements, flooring at 0. load has priority over counting.
// Ports   : CLK, Reset (async, active-high), load, en, frame_tick in;
//           game_time[3:0], zero out.
module dk_round_timer
  import dk_game_pkg::*;
#(
  parameter int ROUND_TIME     = DEF_ROUND_TIME,
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       load,
  input  logic       en,
  input  logic       frame_tick,
  output logic [3:0] game_time,
  output logic       zero
);

  localparam int SEC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [3:0]       game_time_q, game_time_d;

  always_comb begin
    sec_cnt_d   = sec_cnt_q;
    game_time_d = game_time_q;
    if (load) begin
      sec_cnt_d   = '0;
      game_time_d = 4'(ROUND_TIME);
    end else if (en && frame_tick) begin
      if (sec_cnt_q == SEC_W'(FRAMES_PER_SEC - 1)) begin
        sec_cnt_d = '0;
        if (game_time_q != 4'd0) begin
          game_time_d = game_time_q - 4'd1;
        end
      end else begin
        sec_cnt_d = sec_cnt_q + SEC_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sec_cnt_q   <= '0;
      game_time_q <= 4'(ROUND_TIME);
    end else begin
      sec_cnt_q   <= sec_cnt_d;
      game_time_q <= game_time_d;
    end
  end

  assign game_time = game_time_q;
  assign zero      = (game_time_q == 4'd0);

endmodule

// File: rtl/dk_round_controller.sv
// rtl/dk_round_controller.sv - match/round sequencer driven by per-frame hit flags
// Purpose : runs IDLE -> INTRO -> FIGHT -> KO rounds, scores them, declares
//           the match winner and freezes player motion outside FIGHT.
//           Optional macro DK_DOUBLE_KO_POINT_EN: a simultaneous hit scores
//           a point for both players unless that would end the match for both.
// Ports   : CLK, Reset (async, active-high), frame_tick, start_btn,
//           P1_Hit_Detected, P2_Hit_Detected in;
//           gameTime[3:0], P1_Score[2:0], P2_Score[2:0], round_winner[1:0],
//           match_winner[1:0], state_o[2:0], freeze, round_start out.
module dk_round_controller
  import dk_game_pkg::*;
#(
  parameter int ROUND_TIME     = DEF_ROUND_TIME,
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int INTRO_FRAMES   = DEF_INTRO_FRAMES,
  parameter int KO_FRAMES      = DEF_KO_FRAMES,
  parameter int WINS_TO_MATCH  = DEF_WINS_TO_MATCH
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       P1_Hit_Detected,
  input  logic       P2_Hit_Detected,
  output logic [3:0] gameTime,
  output logic [2:0] P1_Score,
  output logic [2:0] P2_Score,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner,
  output logic [2:0] state_o,
  output logic       freeze,
  output logic       round_start
);

  localparam int FRM_MAX = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
  localparam int FRM_W   = $clog2(FRM_MAX + 1);
  localparam logic [2:0] WINS = 3'(WINS_TO_MATCH);

  round_state_e     state_q, state_d;
  logic             start_prev_q;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [2:0]       p1_score_q, p1_score_d;
  logic [2:0]       p2_score_q, p2_score_d;
  logic [1:0]       round_winner_q, round_winner_d;
  logic             round_start_q, round_start_d;

  logic             start_edge;
  logic             timer_load;
  logic             timer_en;
  logic             time_zero;

  assign start_edge = start_btn & ~start_prev_q;

  dk_round_timer #(
    .ROUND_TIME     (ROUND_TIME),
    .FRAMES_PER_SEC (FRAMES_PER_SEC)
  ) u_timer (
    .CLK        (CLK),
    .Reset      (Reset),
    .load       (timer_load),
    .en         (timer_en),
    .frame_tick (frame_tick),
    .game_time  (gameTime),
    .zero       (time_zero)
  );

  always_comb begin
    state_d        = state_q;
    frm_cnt_d      = frm_cnt_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    round_winner_d = round_winner_q;
    round_start_d  = 1'b0;
    timer_load     = 1'b0;
    timer_en       = 1'b0;

    case (state_q)
      IDLE, MATCH_OVER: begin
        timer_load = (state_q == IDLE);
        // A tick coinciding with the start edge is spent here, not in INTRO.
        if (start_edge) begin
          state_d        = INTRO;
          frm_cnt_d      = '0;
          p1_score_d     = 3'd0;
          p2_score_d     = 3'd0;
          round_winner_d = WIN_NONE;
          round_start_d  = 1'b1;
        end
      end

      INTRO: begin
        timer_load = 1'b1;
        if (frame_tick) begin
          if (frm_cnt_q == FRM_W'(INTRO_FRAMES - 1)) begin
            state_d   = FIGHT;
            frm_cnt_d = '0;
          end else begin
            frm_cnt_d = frm_cnt_q + FRM_W'(1);
          end
        end
      end

      FIGHT: begin
        if (frame_tick) begin
          if (P1_Hit_Detected && P2_Hit_Detected) begin
            round_winner_d = WIN_TIE;
            state_d        = KO;
            frm_cnt_d      = '0;
`ifdef DK_DOUBLE_KO_POINT_EN
            // A double KO that would finish the match for both sides scores nothing.
            if (!(sat_inc(p1_score_q, WINS) == WINS && sat_inc(p2_score_q, WINS) == WINS)) begin
              p1_score_d = sat_inc(p1_score_q, WINS);
              p2_score_d = sat_inc(p2_score_q, WINS);
            end
`endif
          end else if (P1_Hit_Detected) begin
            p1_score_d     = sat_inc(p1_score_q, WINS);
            round_winner_d = WIN_P1;
            state_d        = KO;
            frm_cnt_d      = '0;
          end else if (P2_Hit_Detected) begin
            p2_score_d     = sat_inc(p2_score_q, WINS);
            round_winner_d = WIN_P2;
            state_d        = KO;
            frm_cnt_d      = '0;
          end else if (time_zero) begin
            round_winner_d = WIN_TIE;
            state_d        = KO;
            frm_cnt_d      = '0;
          end else begin
            timer_en = 1'b1;
          end
        end
      end

      KO: begin
        if (frame_tick) begin
          if (frm_cnt_q == FRM_W'(KO_FRAMES - 1)) begin
            frm_cnt_d = '0;
            if (p1_score_q == WINS || p2_score_q == WINS) begin
              state_d = MATCH_OVER;
            end else begin
              state_d       = INTRO;
              round_start_d = 1'b1;
            end
          end else begin
            frm_cnt_d = frm_cnt_q + FRM_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      start_prev_q   <= 1'b0;
      frm_cnt_q      <= '0;
      p1_score_q     <= 3'd0;
      p2_score_q     <= 3'd0;
      round_winner_q <= WIN_NONE;
      round_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= start_btn;
      frm_cnt_q      <= frm_cnt_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      round_winner_q <= round_winner_d;
      round_start_q  <= round_start_d;
    end
  end

  always_comb begin
    match_winner = WIN_NONE;
    if (state_q == MATCH_OVER) begin
      if (p1_score_q == WINS) begin
        match_winner = WIN_P1;
      end else if (p2_score_q == WINS) begin
        match_winner = WIN_P2;
      end
    end
  end

  assign P1_Score     = p1_score_q;
  assign P2_Score     = p2_score_q;
  assign round_winner = round_winner_q;
  assign state_o      = state_q;
  assign freeze       = (state_q != FIGHT);
  assign round_start  = round_start_q;

endmodule

// File: tb/tb_dk_round_controller.sv
// tb/tb_dk_round_controller.sv - directed table-driven bench for dk_round_controller
module tb_dk_round_controller;
  import dk_game_pkg::*;

`ifdef DK_DOUBLE_KO_POINT_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif

  logic       CLK = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic       start_btn;
  logic       P1_Hit_Detected;
  logic       P2_Hit_Detected;
  logic [3:0] gameTime;
  logic [2:0] P1_Score;
  logic [2:0] P2_Score;
  logic [1:0] round_winner;
  logic [1:0] match_winner;
  logic [2:0] state_o;
  logic       freeze;
  logic       round_start;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  dk_round_controller #(
    .ROUND_TIME     (3),
    .FRAMES_PER_SEC (4),
    .INTRO_FRAMES   (2),
    .KO_FRAMES      (2),
    .WINS_TO_MATCH  (2)
  ) dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .frame_tick      (frame_tick),
    .start_btn       (start_btn),
    .P1_Hit_Detected (P1_Hit_Detected),
    .P2_Hit_Detected (P2_Hit_Detected),
    .gameTime        (gameTime),
    .P1_Score        (P1_Score),
    .P2_Score        (P2_Score),
    .round_winner    (round_winner),
    .match_winner    (match_winner),
    .state_o         (state_o),
    .freeze          (freeze),
    .round_start     (round_start)
  );

  typedef struct {
    logic       tk, st, p1, p2;
    int         e_state, e_gt, e_s1, e_s2, e_rw, e_mw, e_fz, e_rs;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic tk, st, p1, p2,
                              input int es, egt, es1, es2, erw, emw, efz, ers);
    vec_t v;
    v.tk = tk; v.st = st; v.p1 = p1; v.p2 = p2;
    v.e_state = es; v.e_gt = egt; v.e_s1 = es1; v.e_s2 = es2;
    v.e_rw = erw; v.e_mw = emw; v.e_fz = efz; v.e_rs = ers;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int es, egt, es1, es2, erw, emw, efz, ers);
    chk({tag, ".state"},        int'(state_o),      es);
    chk({tag, ".gameTime"},     int'(gameTime),     egt);
    chk({tag, ".P1_Score"},     int'(P1_Score),     es1);
    chk({tag, ".P2_Score"},     int'(P2_Score),     es2);
    chk({tag, ".round_winner"}, int'(round_winner), erw);
    chk({tag, ".match_winner"}, int'(match_winner), emw);
    chk({tag, ".freeze"},       int'(freeze),       efz);
    chk({tag, ".round_start"},  int'(round_start),  ers);
  endtask

  task automatic drive(input logic tk, st, p1, p2);
    @(negedge CLK);
    frame_tick      = tk;
    start_btn       = st;
    P1_Hit_Detected = p1;
    P2_Hit_Detected = p2;
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0;
    P1_Hit_Detected = 1'b0; P2_Hit_Detected = 1'b0;

    // state: IDLE=0 INTRO=1 FIGHT=2 KO=3 MATCH_OVER=4
    tbl[0] = mk(0, 1, 0, 0,  1, 3, 0, 0, 0, 0, 1, 1); // start -> INTRO, pulse
    tbl[1] = mk(0, 0, 0, 0,  1, 3, 0, 0, 0, 0, 1, 0); // pulse is one cycle
    tbl[2] = mk(1, 0, 0, 0,  1, 3, 0, 0, 0, 0, 1, 0); // intro tick 1
    tbl[3] = mk(1, 0, 0, 0,  2, 3, 0, 0, 0, 0, 0, 0); // intro tick 2 -> FIGHT
    tbl[4] = mk(1, 0, 1, 0,  3, 3, 1, 0, 1, 0, 1, 0); // P1 hit -> KO
    tbl[5] = mk(1, 0, 1, 1,  3, 3, 1, 0, 1, 0, 1, 0); // flags in KO ignored
    tbl[6] = mk(1, 0, 0, 0,  1, 3, 1, 0, 1, 0, 1, 1); // KO done -> INTRO, pulse
    tbl[7] = mk(1, 1, 1, 1,  1, 3, 1, 0, 1, 0, 1, 0); // start and flags ignored in INTRO
    tbl[8] = mk(0, 0, 1, 1,  1, 3, 1, 0, 1, 0, 1, 0); // no tick: no progress
    tbl[9] = mk(1, 0, 0, 0,  2, 3, 1, 0, 1, 0, 0, 0); // -> FIGHT

    @(posedge CLK); #1;
    chk_outs("reset_held", 0, 3, 0, 0, 0, 0, 1, 0);
    @(negedge CLK); Reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk_outs("idle_ignores_tick_hits", 0, 3, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].tk, tbl[i].st, tbl[i].p1, tbl[i].p2);
      chk_outs($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_gt, tbl[i].e_s1,
               tbl[i].e_s2, tbl[i].e_rw, tbl[i].e_mw, tbl[i].e_fz, tbl[i].e_rs);
    end

    // Seconds roll over after 4 ticks; then async reset mid-FIGHT.
    ticks(3);
    chk("fight_3ticks.gameTime", int'(gameTime), 3);
    ticks(1);
    chk("fight_4ticks.gameTime", int'(gameTime), 2);
    #2 Reset = 1'b1;
    #1;
    chk_outs("async_reset", 0, 3, 0, 0, 0, 0, 1, 0);
    @(negedge CLK); Reset = 1'b0;

    // Simultaneous hit from 0/0.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    chk("dbl_pre.state", int'(state_o), 2);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk_outs("double_hit", 3, 3, DBL, DBL, 3, 0, 1, 0);

    // Full timeout round.
    ticks(2);
    chk_outs("ko_to_intro", 1, 3, DBL, DBL, 3, 0, 1, 1);
    ticks(2);
    chk("to_fight.state", int'(state_o), 2);
    for (int s = 2; s >= 0; s--) begin
      ticks(4);
      chk($sformatf("countdown_%0d.gameTime", s), int'(gameTime), s);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("countdown_%0d_notick.gameTime", s), int'(gameTime), s);
    end
    chk("at_zero.state", int'(state_o), 2);
    ticks(1);
    chk_outs("timeout_draw", 3, 0, DBL, DBL, 3, 0, 1, 0);

    // P2 wins the match; start edge coincident with a tick.
    @(negedge CLK); Reset = 1'b1;
    @(negedge CLK); Reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk_outs("start_on_tick", 1, 3, 0, 0, 0, 0, 1, 1);
    ticks(1);
    chk("start_tick_not_counted.state", int'(state_o), 1);
    ticks(1);
    chk("r1_fight.state", int'(state_o), 2);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk_outs("p2_round1", 3, 3, 0, 1, 2, 0, 1, 0);
    ticks(2);
    chk_outs("r2_intro", 1, 3, 0, 1, 2, 0, 1, 1);
    ticks(2);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk_outs("p2_round2", 3, 3, 0, 2, 2, 0, 1, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("match_over", 4, 3, 0, 2, 2, 2, 1, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk_outs("match_over_hold", 4, 3, 0, 2, 2, 2, 1, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk_outs("restart", 1, 3, 0, 0, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
